aes_block_loader: RTL and testbench
===================================

# aes_block_loader

Word-serial front end for the `aes_128` core. It assembles 32-bit plaintext and key words from a valid/ready source into 128-bit `state`/`key` operands. It launches one block per assembly into the fixed-latency, non-stallable AES pipeline, then tags and captures the matching `out` word into a result FIFO drained through a valid/ready sink. Launches are credit-limited, so a captured result is never dropped.

## Interface
- `LATENCY`, 21: cycles from a launch cycle to the cycle `aes_out` carries that block's ciphertext; must match `aes_128`.
- `DEPTH`, 4: result FIFO entries, power of two, ≥2; also the launch credit limit.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-low reset (`rst==0` resets on the next edge).
- `in_valid`  in  1  source word valid.
- `in_ready`  out  1  word accepted when `in_valid && in_ready`.
- `in_sel`  in  1  0 = plaintext word, 1 = key word.
- `in_data`  in  32  word; first word of each group is bits [127:96], fourth is [31:0].
- `aes_state`  out  128  to `aes_128` state input.
- `aes_key`  out  128  to `aes_128` key input.
- `aes_out`  in  128  from `aes_128` out.
- `res_valid`  out  1  FIFO head valid.
- `res_ready`  in  1  sink pop.
- `res_data`  out  128  FIFO head ciphertext.
- `key_loaded`  out  1  a full key has been committed since reset.
- `busy`  out  1  any block in flight or buffered.

## Operation
- Plaintext assembly: 2-bit `pt_cnt` shifts words into `pt_buf`; the 4th accepted word completes the block.
- Key assembly: independent 2-bit `key_cnt` into `key_buf`. The 4th key word commits `key_buf` to `aes_key` on the same edge and sets `key_loaded`.
- Key words are accepted in COLLECT and HOLD. A key commit on the launch edge is not allowed: key words are not accepted in LAUNCH.
- FSM:
  - COLLECT: `in_ready=1`. The 4th plaintext word moves to HOLD.
  - HOLD: `in_ready=1` for key words only, `in_ready=0` for plaintext (ready is computed from `in_sel`). Moves to LAUNCH when `key_loaded && credits>0`.
  - LAUNCH: one cycle, `in_ready=0`. `aes_state` is loaded from `pt_buf` on entry, so it is valid during LAUNCH. A 1 is shifted into the tag pipe, one credit is consumed, and the FSM returns to COLLECT with `pt_cnt=0`.
- `aes_state` holds its last value outside launches; non-launch cycles carry tag 0.
- Tag pipe: LATENCY-bit shift register, bit 0 set in LATENCY and 0 otherwise. When the tag emerges, `aes_out` is pushed into the FIFO that edge.
- Credits: `credits = DEPTH − (tags in pipe + FIFO count)`, kept as a counter.
  - Decremented on launch, incremented on pop.
  - Simultaneous launch and pop leave it unchanged.
- FIFO push with FIFO full cannot occur by construction. The bench asserts this.
- `busy = (credits != DEPTH)`.
- Simultaneous push and pop on a non-empty FIFO: both happen, count unchanged. On an empty FIFO the push lands and the pop is ignored (`res_valid` was 0).
- Reset mid-operation clears tags, FIFO, counters, `key_loaded` and the FSM to COLLECT. In-flight AES results are discarded.

## Timing
- Reset values: `in_ready=0` during reset cycle output, 1 after; `aes_state=0`; `aes_key=0`; `res_valid=0`; `res_data=0`; `key_loaded=0`; `busy=0`.
- Launch cycle is the earliest cycle after the 4th plaintext word edge with the HOLD condition true. Minimum is 1 cycle in HOLD, then LAUNCH.
- Best case: 4th plaintext word on edge t, HOLD at t+1, LAUNCH at t+2, tag out and FIFO push at edge t+2+LATENCY, `res_valid` at t+3+LATENCY.
- Sustained throughput is one block per 6 cycles (4 words + HOLD + LAUNCH) while credits remain.
- `res_data` is registered FIFO head. It is stable while `res_valid && !res_ready`.

## Structure
- Shared package `aes_loader_pkg`: FSM state enum (COLLECT, HOLD, LAUNCH), `WORD_W=32`, `BLK_W=128`, word-index constants.
- Sub-module `aes_res_fifo`: synchronous FIFO, DEPTH×128, with count output. This is the natural split.
- Tag pipe and credit counter stay in the top.

## Test plan
- Load key 000102030405060708090a0b0c0d0e0f, then plaintext 00112233445566778899aabbccddeeff -> `res_data=69c4e0d86a7b0430d8cdb78070b4c55a`, `res_valid` at 4th-pt-word edge + 3 + LATENCY.
- Plaintext before any key -> FSM parks in HOLD with `in_ready=0` for `in_sel=0`. Key words are still accepted, and launch happens 1 cycle after key commit.
- `res_ready=0`, stream 6 blocks -> exactly DEPTH=4 launch. The 5th parks in HOLD with `busy=1` and no FIFO overflow. Raising `res_ready` drains 4 results in order, then the remaining 2 launch.
- Continuous `res_ready=1` with launch and pop in the same cycle -> credits unchanged, results in launch order.
- Assert `rst=0` for one edge with 2 blocks in flight -> no `res_valid` ever for them, `key_loaded=0`, all outputs at reset values.
- Key rewrite between two blocks (FIPS key, then all-zero key) -> the second block with pt 0 gives 66e94bd4ef8a2c3b884cfa59ca342b2e.

Source files
------------

// File: rtl/aes_loader_pkg.sv
// Shared types and constants for the word-serial AES block loader.
package aes_loader_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BLK_W  = 128;

    localparam logic [1:0] WORD_IDX_FIRST = 2'd0;
    localparam logic [1:0] WORD_IDX_LAST  = 2'd3;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        LAUNCH  = 2'd2
    } load_state_e;

    // First word lands in the top slice after four shifts.
    function automatic logic [BLK_W-1:0] shift_word(input logic [BLK_W-1:0] acc_v,
                                                    input logic [WORD_W-1:0] w);
        return {acc_v[BLK_W-WORD_W-1:0], w};
    endfunction

endpackage

// File: rtl/aes_res_fifo.sv
// Result FIFO for ciphertext blocks; pop is only issued when non-empty.
module aes_res_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/aes_block_loader.sv
// Assembles plaintext/key words into AES operands, launches credit-limited
// blocks into the fixed-latency core and queues the tagged results.
module aes_block_loader
    import aes_loader_pkg::*;
#(
    parameter int unsigned LATENCY = 21,
    parameter int unsigned DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
    input  logic [WORD_W-1:0] in_data,
    output logic [BLK_W-1:0]  aes_state,
    output logic [BLK_W-1:0]  aes_key,
    input  logic [BLK_W-1:0]  aes_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [BLK_W-1:0]  res_data,
    output logic              key_loaded,
    output logic              busy
);

    localparam int unsigned CRED_W = $clog2(DEPTH) + 1;

    load_state_e        state_q, state_d;
    logic [1:0]         pt_cnt_q, pt_cnt_d;
    logic [BLK_W-1:0]   pt_buf_q, pt_buf_d;
    logic [1:0]         key_cnt_q, key_cnt_d;
    logic [BLK_W-1:0]   key_buf_q, key_buf_d;
    logic [BLK_W-1:0]   aes_state_q, aes_state_d;
    logic [BLK_W-1:0]   aes_key_q, aes_key_d;
    logic               key_loaded_q, key_loaded_d;
    logic [LATENCY-1:0] tag_q, tag_d;
    logic [CRED_W-1:0]  credits_q, credits_d;

    logic               in_ready_c;
    logic               pt_fire;
    logic               key_fire;
    logic               launch;
    logic               pop_fire;
    logic               push;
    logic [CRED_W-1:0]  fifo_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= COLLECT;
            pt_cnt_q     <= WORD_IDX_FIRST;
            pt_buf_q     <= '0;
            key_cnt_q    <= WORD_IDX_FIRST;
            key_buf_q    <= '0;
            aes_state_q  <= '0;
            aes_key_q    <= '0;
            key_loaded_q <= 1'b0;
            tag_q        <= '0;
            credits_q    <= CRED_W'(DEPTH);
        end else begin
            state_q      <= state_d;
            pt_cnt_q     <= pt_cnt_d;
            pt_buf_q     <= pt_buf_d;
            key_cnt_q    <= key_cnt_d;
            key_buf_q    <= key_buf_d;
            aes_state_q  <= aes_state_d;
            aes_key_q    <= aes_key_d;
            key_loaded_q <= key_loaded_d;
            tag_q        <= tag_d;
            credits_q    <= credits_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pt_cnt_d     = pt_cnt_q;
        pt_buf_d     = pt_buf_q;
        key_cnt_d    = key_cnt_q;
        key_buf_d    = key_buf_q;
        aes_state_d  = aes_state_q;
        aes_key_d    = aes_key_q;
        key_loaded_d = key_loaded_q;
        launch       = 1'b0;
        in_ready_c   = 1'b0;

        // HOLD keeps taking key words so a late key can unblock the parked block.
        case (state_q)
            COLLECT: in_ready_c = 1'b1;
            HOLD:    in_ready_c = in_sel;
            default: in_ready_c = 1'b0;
        endcase
        if (!rst) begin
            in_ready_c = 1'b0;
        end

        pt_fire  = in_valid && in_ready_c && !in_sel;
        key_fire = in_valid && in_ready_c && in_sel;

        if (key_fire) begin
            key_buf_d = shift_word(key_buf_q, in_data);
            key_cnt_d = key_cnt_q + 2'd1;
            if (key_cnt_q == WORD_IDX_LAST) begin
                aes_key_d    = shift_word(key_buf_q, in_data);
                key_loaded_d = 1'b1;
            end
        end

        case (state_q)
            COLLECT: begin
                if (pt_fire) begin
                    pt_buf_d = shift_word(pt_buf_q, in_data);
                    pt_cnt_d = pt_cnt_q + 2'd1;
                    if (pt_cnt_q == WORD_IDX_LAST) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (key_loaded_q && (credits_q != '0)) begin
                    state_d     = LAUNCH;
                    aes_state_d = pt_buf_q;
                end
            end
            LAUNCH: begin
                launch   = 1'b1;
                pt_cnt_d = WORD_IDX_FIRST;
                state_d  = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    // A tag reaching the top bit marks the cycle aes_out holds that block's result.
    assign tag_d    = {tag_q[LATENCY-2:0], launch};
    assign push     = tag_q[LATENCY-1];
    assign pop_fire = res_ready && res_valid;

    always_comb begin
        credits_d = credits_q;
        case ({launch, pop_fire})
            2'b10:   credits_d = credits_q - CRED_W'(1);
            2'b01:   credits_d = credits_q + CRED_W'(1);
            default: credits_d = credits_q;
        endcase
    end

    aes_res_fifo #(
        .DEPTH (DEPTH),
        .W     (BLK_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (aes_out),
        .pop_i   (pop_fire),
        .data_o  (res_data),
        .count_o (fifo_count)
    );

    assign in_ready   = in_ready_c;
    assign aes_state  = aes_state_q;
    assign aes_key    = aes_key_q;
    assign res_valid  = (fifo_count != '0);
    assign key_loaded = key_loaded_q;
    assign busy       = (credits_q != CRED_W'(DEPTH));

endmodule

// File: tb/tb_aes_block_loader.sv
// Randomised bench for aes_block_loader against a queue-based reference model
// with a stand-in fixed-latency AES core.
module tb_aes_block_loader;

    localparam int unsigned LATENCY = 21;
    localparam int unsigned DEPTH   = 4;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk, rst, in_valid, in_ready, in_sel;
    logic         res_valid, res_ready, key_loaded, busy;
    logic [31:0]  in_data;
    logic [127:0] aes_state, aes_key, aes_out, res_data;

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;
    int last_acc = 0;
    int pt_acc = 0;
    int n_pop = 0;
    int sink_mode = 0;
    bit sender_done = 0;

    aes_block_loader #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data), .aes_state(aes_state),
        .aes_key(aes_key), .aes_out(aes_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .key_loaded(key_loaded),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in cipher: real AES answers for the two known vectors, a keyed mix otherwise.
    function automatic logic [127:0] aes_stub(input logic [127:0] s, input logic [127:0] k);
        if (s == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        if (s == '0 && k == '0) return ZERO_CT;
        return {s[120:0], s[127:121]} ^ k ^ 128'h5a5a_0123_4567_89ab_cdef_f00d_beef_1357;
    endfunction

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endfunction

    function automatic void fail_timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting (edge %0d), expected event", name, edge_n);
    endfunction

    // ---------------- reference model ----------------
    typedef struct { int due; logic [127:0] data; } flight_t;
    logic [127:0] m_state = '0, m_key = '0;
    bit           m_key_loaded = 0, m_pending = 0, m_launch = 0, m_live = 0;
    logic [31:0]  m_pt[$];
    logic [31:0]  m_kw[$];
    flight_t      m_fly[$];
    logic [127:0] m_fifo[$];
    logic [127:0] stub_pipe [LATENCY];

    assign aes_out = stub_pipe[LATENCY-1];

    function automatic bit m_ready(input logic sel);
        return (rst === 1'b1) && !m_launch && (!m_pending || (sel === 1'b1));
    endfunction

    always @(posedge clk) begin : model
        int      credits;
        bit      acc, go;
        flight_t f;
        for (int i = LATENCY - 1; i > 0; i--) stub_pipe[i] <= stub_pipe[i-1];
        stub_pipe[0] <= (m_live && m_launch) ? aes_stub(aes_state, aes_key)
                                             : {$urandom, $urandom, $urandom, $urandom};
        edge_n++;
        if (rst !== 1'b1) begin
            m_state = '0; m_key = '0; m_key_loaded = 0; m_pending = 0; m_launch = 0;
            m_pt.delete(); m_kw.delete(); m_fly.delete(); m_fifo.delete();
            m_live = 1;
        end else if (m_live) begin
            credits = int'(DEPTH) - m_fly.size() - m_fifo.size();
            acc = in_valid && m_ready(in_sel);
            go  = m_pending && m_key_loaded && (credits > 0);
            if (res_ready && m_fifo.size() != 0) void'(m_fifo.pop_front());
            if (m_fly.size() != 0 && m_fly[0].due == edge_n) begin
                f = m_fly.pop_front();
                m_fifo.push_back(f.data);
            end
            if (m_launch) begin
                m_fly.push_back('{edge_n + int'(LATENCY), aes_stub(m_state, m_key)});
                m_launch = 0;
            end
            if (acc && in_sel) begin
                m_kw.push_back(in_data);
                if (m_kw.size() == 4) begin
                    m_key = {m_kw[0], m_kw[1], m_kw[2], m_kw[3]};
                    m_key_loaded = 1;
                    m_kw.delete();
                end
            end
            if (go) begin
                m_state = {m_pt[0], m_pt[1], m_pt[2], m_pt[3]};
                m_pt.delete();
                m_pending = 0;
                m_launch = 1;
            end
            if (acc && !in_sel) begin
                m_pt.push_back(in_data);
                if (m_pt.size() == 4) m_pending = 1;
            end
        end
    end

    // Per-cycle comparison plus handshake monitors.
    always @(negedge clk) begin
        if (in_valid && in_ready && !in_sel) pt_acc++;
        if (res_valid && res_ready) n_pop++;
        if (m_live) begin
            chk("in_ready", 128'(in_ready), 128'(m_ready(in_sel)));
            chk("res_valid", 128'(res_valid), 128'(m_fifo.size() != 0));
            if (m_fifo.size() != 0) chk("res_data", res_data, m_fifo[0]);
            chk("key_loaded", 128'(key_loaded), 128'(m_key_loaded));
            chk("busy", 128'(busy), 128'((m_fly.size() + m_fifo.size()) != 0));
            chk("aes_state", aes_state, m_state);
            chk("aes_key", aes_key, m_key);
            chk("fifo_overflow", 128'(dut.tag_q[LATENCY-1] && (dut.fifo_count == 3'(DEPTH))), 128'(0));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (sink_mode)
                0:       res_ready = 1'b0;
                1:       res_ready = 1'b1;
                default: res_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    task automatic send_word(input bit sel, input logic [31:0] d);
        int n = 0;
        in_valid = 1'b1; in_sel = sel; in_data = d;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 500) begin n++; @(negedge clk); end
        if (in_ready !== 1'b1) begin
            fail_timeout("word_accept");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        last_acc = edge_n;
        in_valid = 1'b0;
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    endtask

    task automatic send_blk(input bit sel, input logic [127:0] v);
        for (int i = 0; i < 4; i++) send_word(sel, v[127 - 32*i -: 32]);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_res(input string name, output int e);
        int n = 0;
        @(negedge clk);
        while (res_valid !== 1'b1 && n < 400) begin n++; @(negedge clk); end
        if (res_valid !== 1'b1) begin fail_timeout(name); e = -1; end
        else e = edge_n;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || m_pending) && n < 1000) begin n++; @(negedge clk); end
        if (busy !== 1'b0) fail_timeout(name);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        chk({tag, "_aes_state"}, aes_state, '0);
        chk({tag, "_aes_key"}, aes_key, '0);
        chk({tag, "_res_valid"}, 128'(res_valid), 128'(0));
        chk({tag, "_res_data"}, res_data, '0);
        chk({tag, "_key_loaded"}, 128'(key_loaded), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
    endtask

    initial begin
        int e, t, n, saw;
        rst = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b1;
        chk_reset_vals("reset");
        @(posedge clk); #1;

        // Plaintext before any key parks in HOLD; key words still flow.
        sink_mode = 1;
        send_blk(1'b0, '0);
        repeat (4) begin @(posedge clk); #1; end
        in_valid = 1'b1; in_sel = 1'b0; in_data = '0;
        @(negedge clk);
        chk("hold_pt_ready", 128'(in_ready), 128'(0));
        chk("hold_busy", 128'(busy), 128'(0));
        in_sel = 1'b1; #1;
        chk("hold_key_ready", 128'(in_ready), 128'(1));
        in_valid = 1'b0;
        @(posedge clk); #1;
        send_blk(1'b1, '0);
        t = last_acc;
        wait_res("zero_res", e);
        chk("late_key_latency", 128'(e - t), 128'(LATENCY + 2));
        chk("zero_kat", res_data, ZERO_CT);
        wait_idle("idle_a");

        // FIPS-197 known answer with best-case timing.
        sink_mode = 0;
        @(posedge clk); #1;
        send_blk(1'b1, FIPS_KEY);
        send_blk(1'b0, FIPS_PT);
        t = last_acc;
        wait_res("fips_res", e);
        chk("fips_latency", 128'(e - t), 128'(LATENCY + 2));
        chk("fips_kat", res_data, FIPS_CT);
        sink_mode = 1;
        wait_idle("idle_b");

        // Credit limit: six blocks with the sink stalled.
        sink_mode = 0;
        @(posedge clk); #1;
        pt_acc = 0; n_pop = 0; sender_done = 0;
        fork
            begin
                for (int b = 0; b < 6; b++) send_blk(1'b0, rnd128());
                sender_done = 1;
            end
        join_none
        repeat (120) @(posedge clk);
        @(negedge clk);
        chk("credit_pt_words", 128'(pt_acc), 128'(20));
        chk("credit_model_fifo", 128'(m_fifo.size()), 128'(DEPTH));
        chk("credit_res_valid", 128'(res_valid), 128'(1));
        chk("credit_busy", 128'(busy), 128'(1));
        chk("credit_stall", 128'(in_ready), 128'(0));
        sink_mode = 1;
        n = 0;
        while (!sender_done && n < 1000) begin n++; @(posedge clk); end
        if (!sender_done) fail_timeout("credit_sender");
        #1;
        wait_idle("idle_c");
        chk("credit_pops", 128'(n_pop), 128'(6));
        chk("credit_pt_total", 128'(pt_acc), 128'(24));

        // Streaming with occasional key rewrites, then a random sink.
        for (int b = 0; b < 16; b++) begin
            sink_mode = (b < 8) ? 1 : 2;
            if ($urandom_range(0, 2) == 0) send_blk(1'b1, rnd128());
            send_blk(1'b0, rnd128());
        end
        sink_mode = 1;
        wait_idle("idle_d");

        // Reset with two blocks in flight discards them.
        sink_mode = 0;
        send_blk(1'b0, rnd128());
        send_blk(1'b0, rnd128());
        repeat (3) begin @(posedge clk); #1; end
        chk("inflight_two", 128'(m_fly.size()), 128'(2));
        do_reset();
        chk_reset_vals("midrst");
        saw = 0;
        repeat (2 * LATENCY) begin
            @(negedge clk);
            if (res_valid !== 1'b0) saw++;
        end
        chk("midrst_no_result", 128'(saw), 128'(0));
        @(posedge clk); #1;

        // Key rewrite between two blocks.
        sink_mode = 1;
        send_blk(1'b1, FIPS_KEY);
        send_blk(1'b0, FIPS_PT);
        wait_res("rewrite_res1", e);
        chk("rewrite_kat1", res_data, FIPS_CT);
        @(posedge clk); #1;
        send_blk(1'b1, '0);
        send_blk(1'b0, '0);
        wait_res("rewrite_res2", e);
        chk("rewrite_kat2", res_data, ZERO_CT);
        wait_idle("idle_e");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: run did not complete, expected finish before 50000 cycles");
        $fatal(1, "global timeout");
    end

endmodule
